fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fq_ptr.sv | 37 +++
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional same-cycle bypass is enabled with FETCH_QUEUE_BYPASS_EN.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Modulo-DEPTH queue pointer with increment, synchronous clear
// and asynchronous reset.
module fq_ptr #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // DEPTH is a power of two, so the natural overflow is the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with redirect flush.
// Define FETCH_QUEUE_BYPASS_EN for empty-queue same-cycle bypass.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             ReSet,
    input  logic [WIDTH-1:0] InPC,
    input  logic [WIDTH-1:0] InInstr,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Flush,
    output logic [WIDTH-1:0] OutPC,
    output logic [WIDTH-1:0] OutInstr,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [CW-1:0]    Count
);

    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    fq_entry_t     mem_q [DEPTH];
    fq_entry_t     head;

    logic empty;
    logic full;
    logic enq;
    logic deq;
    logic bypass;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && InValid && OutReady && !Flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed directly and never stored.
    assign enq = InValid && !full && !Flush && !bypass;
    assign deq = !empty && OutReady && !Flush;

    assign InReady  = !full;
    assign OutValid = (!empty && !Flush) || bypass;
    assign Count    = count_q;

    assign head = mem_q[rd_ptr];

    always_comb begin
        OutPC    = WIDTH'(RESET_VECTOR);
        OutInstr = WIDTH'(NOP_INSTR);
        if (bypass) begin
            OutPC    = InPC;
            OutInstr = InInstr;
        end else if (!empty) begin
            OutPC    = WIDTH'(head.pc);
            OutInstr = WIDTH'(head.instr);
        end
    end

    always_comb begin
        count_d = count_q;
        if (Flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge Clk or posedge ReSet) begin
        if (ReSet) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; Count gates its visibility.
    always_ff @(posedge Clk) begin
        if (enq) begin
            mem_q[wr_ptr] <= '{pc: XLEN'(InPC), instr: XLEN'(InInstr)};
        end
    end

    fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i (Clk),
        .rst_i (ReSet),
        .clr_i (Flush),
        .inc_i (enq),
        .ptr_o (wr_ptr)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i (Clk),
        .rst_i (ReSet),
        .clr_i (Flush),
        .inc_i (deq),
        .ptr_o (rd_ptr)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// Covers both builds of FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

    logic        Clk = 1'b0;
    logic        ReSet;
    logic [31:0] InPC;
    logic [31:0] InInstr;
    logic        InValid;
    logic        InReady;
    logic        Flush;
    logic [31:0] OutPC;
    logic [31:0] OutInstr;
    logic        OutValid;
    logic        OutReady;
    logic [2:0]  Count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .Clk      (Clk),
        .ReSet    (ReSet),
        .InPC     (InPC),
        .InInstr  (InInstr),
        .InValid  (InValid),
        .InReady  (InReady),
        .Flush    (Flush),
        .OutPC    (OutPC),
        .OutInstr (OutInstr),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Count    (Count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push(input logic [31:0] pc);
        InValid = 1'b1;
        InPC    = pc;
        InInstr = ins(pc);
        tick();
        InValid = 1'b0;
    endtask

    task automatic test_reset;
        OutReady = 1'b0;
        push(32'h100);
        push(32'h104);
        push(32'h108);
        total++;
        if (Count !== 3'd3) begin
            bad++;
            $display("FAIL reset_pre_count got=%0d exp=3", Count);
        end
        @(posedge Clk);
        #2;
        ReSet = 1'b1;
        #1;
        total++;
        if (Count !== 3'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d exp=0", Count);
        end
        total++;
        if (OutValid !== 1'b0) begin
            bad++;
            $display("FAIL reset_outvalid got=%b exp=0", OutValid);
        end
        total++;
        if (InReady !== 1'b1) begin
            bad++;
            $display("FAIL reset_inready got=%b exp=1", InReady);
        end
        total++;
        if (OutPC !== 32'h0000_3000) begin
            bad++;
            $display("FAIL reset_outpc got=%h exp=00003000", OutPC);
        end
        total++;
        if (OutInstr !== 32'h0) begin
            bad++;
            $display("FAIL reset_outinstr got=%h exp=0", OutInstr);
        end
        @(negedge Clk);
        ReSet = 1'b0;
        tick();
    endtask

    task automatic test_fill;
        logic [31:0] pc;
        OutReady = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h3000 + 32'(4 * i));
        total++;
        if (Count !== 3'd4) begin
            bad++;
            $display("FAIL fill_count got=%0d exp=4", Count);
        end
        total++;
        if (InReady !== 1'b0) begin
            bad++;
            $display("FAIL fill_inready got=%b exp=0", InReady);
        end
        InValid = 1'b1;
        InPC    = 32'h3010;
        InInstr = ins(32'h3010);
        tick();
        tick();
        InValid = 1'b0;
        total++;
        if (Count !== 3'd4 || OutPC !== 32'h3000) begin
            bad++;
            $display("FAIL fill_held got=%0d/%h exp=4/00003000", Count, OutPC);
        end
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h3000 + 32'(4 * i);
            #1;
            total++;
            if (OutValid !== 1'b1 || OutPC !== pc || OutInstr !== ins(pc)) begin
                bad++;
                $display("FAIL fill_drain%0d got=%b/%h/%h exp=1/%h/%h",
                         i, OutValid, OutPC, OutInstr, pc, ins(pc));
            end
            tick();
        end
        total++;
        if (Count !== 3'd0 || OutValid !== 1'b0) begin
            bad++;
            $display("FAIL fill_empty got=%0d/%b exp=0/0", Count, OutValid);
        end
        OutReady = 1'b0;
    endtask

    task automatic test_stream;
        logic [31:0] pc;
        InValid  = 1'b1;
        OutReady = 1'b1;
`ifdef FETCH_QUEUE_BYPASS_EN
        for (int k = 0; k < 10; k++) begin
            pc      = 32'h3000 + 32'(4 * k);
            InPC    = pc;
            InInstr = ins(pc);
            #1;
            total++;
            if (OutValid !== 1'b1 || OutPC !== pc || Count !== 3'd0) begin
                bad++;
                $display("FAIL stream%0d got=%b/%h/%0d exp=1/%h/0",
                         k, OutValid, OutPC, Count, pc);
            end
            tick();
        end
        InValid = 1'b0;
`else
        for (int k = 0; k <= 10; k++) begin
            InPC    = 32'h3000 + 32'(4 * k);
            InInstr = ins(InPC);
            if (k > 0) begin
                pc = 32'h3000 + 32'(4 * (k - 1));
                #1;
                total++;
                if (OutValid !== 1'b1 || OutPC !== pc || OutInstr !== ins(pc)
                    || Count !== 3'd1) begin
                    bad++;
                    $display("FAIL stream%0d got=%b/%h/%0d exp=1/%h/1",
                             k, OutValid, OutPC, Count, pc);
                end
            end
            tick();
        end
        InValid = 1'b0;
        total++;
        if (OutPC !== 32'h3028) begin
            bad++;
            $display("FAIL stream_tail got=%h exp=00003028", OutPC);
        end
        tick();
`endif
        total++;
        if (Count !== 3'd0) begin
            bad++;
            $display("FAIL stream_end got=%0d exp=0", Count);
        end
        OutReady = 1'b0;
    endtask

    task automatic test_flush;
        OutReady = 1'b0;
        push(32'h3000);
        push(32'h3004);
        push(32'h3008);
        Flush   = 1'b1;
        InValid = 1'b1;
        InPC    = 32'h3010;
        InInstr = ins(32'h3010);
        #1;
        total++;
        if (OutValid !== 1'b0) begin
            bad++;
            $display("FAIL flush_mask got=%b exp=0", OutValid);
        end
        tick();
        Flush   = 1'b0;
        InValid = 1'b0;
        #1;
        total++;
        if (Count !== 3'd0 || OutValid !== 1'b0) begin
            bad++;
            $display("FAIL flush_empty got=%0d/%b exp=0/0", Count, OutValid);
        end
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (OutValid !== 1'b0) begin
                bad++;
                $display("FAIL flush_leak%0d got=%h exp=none", i, OutPC);
            end
        end
        OutReady = 1'b0;
        push(32'h3040);
        total++;
        if (OutPC !== 32'h3040 || Count !== 3'd1) begin
            bad++;
            $display("FAIL flush_restart got=%h/%0d exp=00003040/1", OutPC, Count);
        end
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
    endtask

    task automatic test_full_deq;
        OutReady = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h3000 + 32'(4 * i));
        InValid  = 1'b1;
        InPC     = 32'h3020;
        InInstr  = ins(32'h3020);
        OutReady = 1'b1;
        #1;
        total++;
        if (InReady !== 1'b0) begin
            bad++;
            $display("FAIL fulldeq_inready got=%b exp=0", InReady);
        end
        tick();
        InValid = 1'b0;
        total++;
        if (Count !== 3'd3 || OutPC !== 32'h3004) begin
            bad++;
            $display("FAIL fulldeq_count got=%0d/%h exp=3/00003004", Count, OutPC);
        end
        tick();
        tick();
        tick();
        total++;
        if (Count !== 3'd0 || OutValid !== 1'b0) begin
            bad++;
            $display("FAIL fulldeq_drop got=%0d/%b exp=0/0", Count, OutValid);
        end
        OutReady = 1'b0;
    endtask

    task automatic test_bypass;
        InValid  = 1'b1;
        InPC     = 32'h3000;
        InInstr  = 32'h2008_0001;
        OutReady = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        total++;
        if (OutValid !== 1'b1 || OutInstr !== 32'h2008_0001 || OutPC !== 32'h3000) begin
            bad++;
            $display("FAIL bypass_same got=%b/%h/%h exp=1/00003000/20080001",
                     OutValid, OutPC, OutInstr);
        end
        tick();
        InValid = 1'b0;
        total++;
        if (Count !== 3'd0) begin
            bad++;
            $display("FAIL bypass_count got=%0d exp=0", Count);
        end
`else
        total++;
        if (OutValid !== 1'b0 || OutPC !== 32'h3000 || OutInstr !== 32'h0) begin
            bad++;
            $display("FAIL nobypass_same got=%b/%h/%h exp=0/00003000/0",
                     OutValid, OutPC, OutInstr);
        end
        tick();
        InValid = 1'b0;
        total++;
        if (Count !== 3'd1 || OutValid !== 1'b1 || OutInstr !== 32'h2008_0001) begin
            bad++;
            $display("FAIL nobypass_next got=%0d/%b/%h exp=1/1/20080001",
                     Count, OutValid, OutInstr);
        end
        tick();
        total++;
        if (Count !== 3'd0) begin
            bad++;
            $display("FAIL nobypass_drain got=%0d exp=0", Count);
        end
`endif
        OutReady = 1'b0;
    endtask

    initial begin
        ReSet    = 1'b1;
        InPC     = '0;
        InInstr  = '0;
        InValid  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b0;
        tick();
        tick();
        ReSet = 1'b0;
        tick();
        test_reset();
        test_fill();
        test_stream();
        test_flush();
        test_full_deq();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
